// File: rtl/ins_dec_pipe.sv
// ----------------------------------------------------------------------------
// ins_dec_pipe
//   Pipelined instruction decoder between fetch and execute. Picks one
//   instruction lane out of the IMEM fetch word, decodes it and holds the
//   decoded bundle in a one-deep output register. Valid/ready handshakes on
//   both sides. A per-register pending scoreboard stalls read-after-write
//   hazards, and a saturating counter records the cycles lost to them.
//
//   Opcode encoding (func_t):
//     ADD=0 SUB=1 AND=2 OR=3 XOR=4 NOT=5 ADDI=6 LOAD=7 STORE=8
//     SLL=9 SLR=10 SLLI=11 SLRI=12; all other codes are illegal.
//
//   Instruction layout, LSB first: opcode | imm | rs1 | rd.
//   rs2 is the top RA_WIDTH bits of the imm field.
//
// Ports
//   clk_i, arst_ni           clock, asynchronous active-low reset
//   flush_i                  drop held bundle and clear the scoreboard
//   in_valid_i / in_ready_o  fetch-side handshake
//   imem_rdata_i             fetch word (FETCH_WIDTH bits)
//   imem_addr_i              byte address of the instruction
//   out_valid_o / out_ready_i execute-side handshake
//   func_o, we_o, rd/rs1/rs2_addr_o, imm_o, illegal_o, pc_o  decoded bundle
//   wb_valid_i, wb_addr_i    writeback completion, clears a pending bit
//   stall_cnt_o              saturating count of hazard-stall cycles
// ----------------------------------------------------------------------------
module ins_dec_pipe #(
    parameter int INSTR_WIDTH = 16,
    parameter int FETCH_WIDTH = 32,
    parameter int OPC_WIDTH   = 4,
    parameter int NUM_REGS    = 8,
    parameter int RA_WIDTH    = $clog2(NUM_REGS),
    parameter int IMM_WIDTH   = 6,
    parameter int ADDR_WIDTH  = 32,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [FETCH_WIDTH-1:0] imem_rdata_i,
    input  logic [ADDR_WIDTH-1:0] imem_addr_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [OPC_WIDTH-1:0]  func_o,
    output logic                  we_o,
    output logic [RA_WIDTH-1:0]   rd_addr_o,
    output logic [RA_WIDTH-1:0]   rs1_addr_o,
    output logic [RA_WIDTH-1:0]   rs2_addr_o,
    output logic [IMM_WIDTH-1:0]  imm_o,
    output logic                  illegal_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    input  logic                  wb_valid_i,
    input  logic [RA_WIDTH-1:0]   wb_addr_i,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

    localparam int NUM_LANES = FETCH_WIDTH / INSTR_WIDTH;
    localparam int LANE_LSB  = $clog2(INSTR_WIDTH / 8);
    localparam int LANE_BITS = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    localparam logic [OPC_WIDTH-1:0] OPC_ADD   = OPC_WIDTH'(0);
    localparam logic [OPC_WIDTH-1:0] OPC_SUB   = OPC_WIDTH'(1);
    localparam logic [OPC_WIDTH-1:0] OPC_AND   = OPC_WIDTH'(2);
    localparam logic [OPC_WIDTH-1:0] OPC_OR    = OPC_WIDTH'(3);
    localparam logic [OPC_WIDTH-1:0] OPC_XOR   = OPC_WIDTH'(4);
    localparam logic [OPC_WIDTH-1:0] OPC_NOT   = OPC_WIDTH'(5);
    localparam logic [OPC_WIDTH-1:0] OPC_ADDI  = OPC_WIDTH'(6);
    localparam logic [OPC_WIDTH-1:0] OPC_LOAD  = OPC_WIDTH'(7);
    localparam logic [OPC_WIDTH-1:0] OPC_STORE = OPC_WIDTH'(8);
    localparam logic [OPC_WIDTH-1:0] OPC_SLL   = OPC_WIDTH'(9);
    localparam logic [OPC_WIDTH-1:0] OPC_SLR   = OPC_WIDTH'(10);
    localparam logic [OPC_WIDTH-1:0] OPC_SLLI  = OPC_WIDTH'(11);
    localparam logic [OPC_WIDTH-1:0] OPC_SLRI  = OPC_WIDTH'(12);

    // Parameter sanity: fields must exactly fill the instruction, and the
    // fetch word must hold a whole number of instructions.
    if (INSTR_WIDTH != OPC_WIDTH + IMM_WIDTH + 2 * RA_WIDTH) begin : g_bad_layout
        $fatal(1, "ins_dec_pipe: INSTR_WIDTH does not match field widths");
    end
    if (FETCH_WIDTH % INSTR_WIDTH != 0) begin : g_bad_fetch
        $fatal(1, "ins_dec_pipe: FETCH_WIDTH not a multiple of INSTR_WIDTH");
    end

    // ------------------------------------------------------------------
    // Lane select
    // ------------------------------------------------------------------
    logic [INSTR_WIDTH-1:0] lanes [NUM_LANES];
    logic [INSTR_WIDTH-1:0] instr;

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        assign lanes[gi] = imem_rdata_i[gi*INSTR_WIDTH +: INSTR_WIDTH];
    end

    if (NUM_LANES > 1) begin : g_lane_mux
        assign instr = lanes[imem_addr_i[LANE_LSB +: LANE_BITS]];
    end else begin : g_lane_single
        assign instr = lanes[0];
    end

    // ------------------------------------------------------------------
    // Field extraction and opcode classification
    // ------------------------------------------------------------------
    logic [OPC_WIDTH-1:0] dec_func;
    logic [IMM_WIDTH-1:0] dec_imm;
    logic [RA_WIDTH-1:0]  dec_rs1;
    logic [RA_WIDTH-1:0]  dec_rs2;
    logic [RA_WIDTH-1:0]  dec_rd;
    logic                 dec_legal;
    logic                 dec_uses_rs2;
    logic                 dec_we;

    assign dec_func = instr[OPC_WIDTH-1:0];
    assign dec_imm  = instr[OPC_WIDTH +: IMM_WIDTH];
    assign dec_rs1  = instr[OPC_WIDTH+IMM_WIDTH +: RA_WIDTH];
    assign dec_rd   = instr[OPC_WIDTH+IMM_WIDTH+RA_WIDTH +: RA_WIDTH];
    assign dec_rs2  = dec_imm[IMM_WIDTH-1 -: RA_WIDTH];

    always_comb begin
        dec_legal    = 1'b0;
        dec_uses_rs2 = 1'b0;
        case (dec_func)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_XOR,
            OPC_SLL, OPC_SLR, OPC_STORE: begin
                dec_legal    = 1'b1;
                dec_uses_rs2 = 1'b1;
            end
            OPC_ADDI, OPC_NOT, OPC_LOAD, OPC_SLLI, OPC_SLRI: begin
                dec_legal = 1'b1;
            end
            default: ;
        endcase
    end

    assign dec_we = dec_legal && (dec_func != OPC_STORE);

    // ------------------------------------------------------------------
    // Scoreboard hazard check; a writeback landing this cycle bypasses it
    // ------------------------------------------------------------------
    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic                wb_hit_rs1, wb_hit_rs2;
    logic                hazard;
    logic                out_valid_q, out_valid_d;
    logic                accept;

    assign wb_hit_rs1 = wb_valid_i && (wb_addr_i == dec_rs1);
    assign wb_hit_rs2 = wb_valid_i && (wb_addr_i == dec_rs2);

    // Illegal opcodes never stall: they write nothing, so ordering is moot.
    assign hazard = in_valid_i && dec_legal &&
                    ((pend_q[dec_rs1] && !wb_hit_rs1) ||
                     (dec_uses_rs2 && pend_q[dec_rs2] && !wb_hit_rs2));

    assign in_ready_o = !hazard && (!out_valid_q || out_ready_i) && !flush_i;
    assign accept     = in_valid_i && in_ready_o;

    // Set on issue wins over a same-cycle writeback to the same register:
    // the new writer is younger than the one completing.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pend
        logic set_hit, clr_hit;
        assign set_hit = accept && dec_we && (dec_rd == RA_WIDTH'(gi));
        assign clr_hit = wb_valid_i && (wb_addr_i == RA_WIDTH'(gi));
        assign pend_d[gi] = flush_i ? 1'b0 :
                            set_hit ? 1'b1 :
                            clr_hit ? 1'b0 : pend_q[gi];
    end

    // ------------------------------------------------------------------
    // Output register next-state
    // ------------------------------------------------------------------
    logic [OPC_WIDTH-1:0]  func_q, func_d;
    logic                  we_q, we_d;
    logic                  illegal_q, illegal_d;
    logic [RA_WIDTH-1:0]   rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [IMM_WIDTH-1:0]  imm_q, imm_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;

    always_comb begin
        func_d      = func_q;
        we_d        = we_q;
        illegal_d   = illegal_q;
        rd_d        = rd_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        imm_d       = imm_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        stall_cnt_d = stall_cnt_q;

        if (accept) begin
            func_d    = dec_func;
            we_d      = dec_we;
            illegal_d = !dec_legal;
            rd_d      = dec_rd;
            rs1_d     = dec_rs1;
            rs2_d     = dec_rs2;
            imm_d     = dec_imm;
            pc_d      = imem_addr_i;
        end

        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end

        // Counts regardless of flush state of the pipe, but a flush cycle
        // is never a stall since nothing could be accepted anyway.
        if (hazard && !flush_i && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            out_valid_q <= 1'b0;
            func_q      <= '0;
            we_q        <= 1'b0;
            illegal_q   <= 1'b0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            imm_q       <= '0;
            pc_q        <= '0;
            pend_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            func_q      <= func_d;
            we_q        <= we_d;
            illegal_q   <= illegal_d;
            rd_q        <= rd_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            imm_q       <= imm_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign func_o      = func_q;
    assign we_o        = we_q;
    assign illegal_o   = illegal_q;
    assign rd_addr_o   = rd_q;
    assign rs1_addr_o  = rs1_q;
    assign rs2_addr_o  = rs2_q;
    assign imm_o       = imm_q;
    assign pc_o        = pc_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_ins_dec_pipe.sv
// ----------------------------------------------------------------------------
// tb_ins_dec_pipe
//   Directed bench for ins_dec_pipe. A second instance with a 2-bit stall
//   counter shares all inputs so counter saturation can be observed.
//   Inputs change 1 time unit after the rising edge; registered outputs are
//   sampled at the same point, combinational in_ready_o after inputs settle.
// ----------------------------------------------------------------------------
module tb_ins_dec_pipe;

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, ADDI = 4'd6, STORE = 4'd8, BAD = 4'd13;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        flush, in_valid, out_ready, wb_valid;
    logic [31:0] rdata, addr;
    logic [2:0]  wb_addr;

    logic        in_ready, out_valid, we, illegal;
    logic [3:0]  func;
    logic [2:0]  rd, rs1, rs2;
    logic [5:0]  imm;
    logic [31:0] pc;
    logic [15:0] stall_cnt;

    logic        s_in_ready, s_out_valid, s_we, s_illegal;
    logic [3:0]  s_func;
    logic [2:0]  s_rd, s_rs1, s_rs2;
    logic [5:0]  s_imm;
    logic [31:0] s_pc;
    logic [1:0]  s_stall_cnt;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    ins_dec_pipe dut (
        .clk_i(clk), .arst_ni(arst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .imem_rdata_i(rdata), .imem_addr_i(addr),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .func_o(func), .we_o(we), .rd_addr_o(rd), .rs1_addr_o(rs1),
        .rs2_addr_o(rs2), .imm_o(imm), .illegal_o(illegal), .pc_o(pc),
        .wb_valid_i(wb_valid), .wb_addr_i(wb_addr), .stall_cnt_o(stall_cnt)
    );

    ins_dec_pipe #(.CNT_WIDTH(2)) dut_s (
        .clk_i(clk), .arst_ni(arst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(s_in_ready),
        .imem_rdata_i(rdata), .imem_addr_i(addr),
        .out_valid_o(s_out_valid), .out_ready_i(out_ready),
        .func_o(s_func), .we_o(s_we), .rd_addr_o(s_rd), .rs1_addr_o(s_rs1),
        .rs2_addr_o(s_rs2), .imm_o(s_imm), .illegal_o(s_illegal), .pc_o(s_pc),
        .wb_valid_i(wb_valid), .wb_addr_i(wb_addr), .stall_cnt_o(s_stall_cnt)
    );

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [2:0] d,
                                        input logic [2:0] s1, input logic [5:0] im);
        return {d, s1, im, op};
    endfunction

    // Register-register form: rs2 sits in the top three imm bits.
    function automatic logic [15:0] rr(input logic [3:0] op, input logic [2:0] d,
                                       input logic [2:0] s1, input logic [2:0] s2);
        return {d, s1, s2, 3'b000, op};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        $display("check %-18s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        arst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        wb_valid = 1'b0; wb_addr = 3'd0; rdata = 32'd0; addr = 32'd0;
        #12;
        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_we",        32'(we),        32'd0);
        chk("rst_pc",        pc,             32'd0);
        chk("rst_stall",     32'(stall_cnt), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        arst_n = 1'b1;
        tick();

        // Lane select: upper half of word at byte address 2
        addr = 32'h2;
        rdata = {rr(ADD, 3'd3, 3'd1, 3'd2), ins(ADDI, 3'd7, 3'd7, 6'h3f)};
        in_valid = 1'b1;
        #1 chk("lane_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("lane_valid", 32'(out_valid), 32'd1);
        chk("lane_func",  32'(func),      32'(ADD));
        chk("lane_rd",    32'(rd),        32'd3);
        chk("lane_rs1",   32'(rs1),       32'd1);
        chk("lane_rs2",   32'(rs2),       32'd2);
        chk("lane_we",    32'(we),        32'd1);
        chk("lane_pc",    pc,             32'h2);
        wb_valid = 1'b1; wb_addr = 3'd3;
        tick();
        wb_valid = 1'b0;
        chk("drain_valid", 32'(out_valid), 32'd0);

        // RAW stall on r4
        addr = 32'h0;
        rdata = {16'h0, ins(ADDI, 3'd4, 3'd0, 6'd5)};
        in_valid = 1'b1;
        tick();
        rdata = {16'h0, rr(SUB, 3'd5, 3'd4, 3'd1)};
        #1 chk("raw_in_ready0", 32'(in_ready), 32'd0);
        chk("raw_stall0", 32'(stall_cnt), 32'd0);
        tick();
        chk("raw_stall1", 32'(stall_cnt), 32'd1);
        chk("raw_in_ready1", 32'(in_ready), 32'd0);
        tick();
        chk("raw_stall2", 32'(stall_cnt), 32'd2);
        wb_valid = 1'b1; wb_addr = 3'd4;
        #1 chk("raw_bypass_ready", 32'(in_ready), 32'd1);
        tick();
        wb_valid = 1'b0; in_valid = 1'b0;
        chk("raw_stall_hold", 32'(stall_cnt), 32'd2);
        chk("raw_func",  32'(func), 32'(SUB));
        chk("raw_rd",    32'(rd),   32'd5);
        chk("raw_rs1",   32'(rs1),  32'd4);

        // Backpressure: SUB held for three cycles
        out_ready = 1'b0;
        addr = 32'h2;
        rdata = {rr(ADD, 3'd6, 3'd1, 3'd2), 16'h0};
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_func",  32'(func),      32'(SUB));
            chk("bp_rd",    32'(rd),        32'd5);
        end
        chk("bp_no_stall", 32'(stall_cnt), 32'd2);
        out_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        chk("b2b_rd0", 32'(rd), 32'd6);
        chk("b2b_pc0", pc,      32'h2);
        addr = 32'h0;
        rdata = {16'h0, rr(ADD, 3'd7, 3'd1, 3'd2)};
        tick();
        chk("b2b_rd1",    32'(rd),        32'd7);
        chk("b2b_pc1",    pc,             32'h0);
        chk("b2b_valid1", 32'(out_valid), 32'd1);

        // Illegal opcode: rs1=r5 is pending but must not stall
        rdata = {16'h0, ins(BAD, 3'd1, 3'd5, 6'd0)};
        #1 chk("ill_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("ill_illegal", 32'(illegal), 32'd1);
        chk("ill_we",      32'(we),      32'd0);
        // Reading r1 must not stall: illegal op did not scoreboard it
        rdata = {16'h0, ins(ADDI, 3'd2, 3'd1, 6'd3)};
        #1 chk("ill_no_pend", 32'(in_ready), 32'd1);
        tick();
        chk("addi_illegal", 32'(illegal), 32'd0);
        chk("addi_rd",      32'(rd),      32'd2);

        // Flush while holding ADDI r2; dependent presented during the flush
        out_ready = 1'b0;
        flush = 1'b1;
        rdata = {16'h0, rr(ADD, 3'd3, 3'd2, 3'd2)};
        #1 chk("fl_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_stall", 32'(stall_cnt), 32'd2);
        #1 chk("fl_dep_ready", 32'(in_ready), 32'd1);
        tick();
        chk("fl_dep_valid", 32'(out_valid), 32'd1);
        chk("fl_dep_rd",    32'(rd),        32'd3);

        // STORE r6: no write enable, no scoreboard entry
        out_ready = 1'b1;
        rdata = {16'h0, rr(STORE, 3'd6, 3'd1, 3'd2)};
        tick();
        chk("st_func",    32'(func),    32'(STORE));
        chk("st_we",      32'(we),      32'd0);
        chk("st_illegal", 32'(illegal), 32'd0);
        rdata = {16'h0, rr(ADD, 3'd1, 3'd6, 3'd6)};
        #1 chk("st_no_pend", 32'(in_ready), 32'd1);
        tick();
        chk("st_dep_rd", 32'(rd), 32'd1);

        // Three more stall cycles on r1: 16-bit counter reaches 5, 2-bit saturates
        rdata = {16'h0, rr(SUB, 3'd4, 3'd1, 3'd0)};
        for (int i = 0; i < 3; i++) tick();
        chk("sat_cnt16", 32'(stall_cnt),   32'd5);
        chk("sat_cnt2",  32'(s_stall_cnt), 32'd3);

        // Release r1, hold the SUB, then reset mid-hold
        out_ready = 1'b0;
        wb_valid = 1'b1; wb_addr = 3'd1;
        tick();
        wb_valid = 1'b0; in_valid = 1'b0;
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_rd",    32'(rd),        32'd4);
        #2 arst_n = 1'b0;
        #1;
        chk("arst_valid",  32'(out_valid),   32'd0);
        chk("arst_func",   32'(func),        32'd0);
        chk("arst_rd",     32'(rd),          32'd0);
        chk("arst_rs1",    32'(rs1),         32'd0);
        chk("arst_imm",    32'(imm),         32'd0);
        chk("arst_pc",     pc,               32'd0);
        chk("arst_stall",  32'(stall_cnt),   32'd0);
        chk("arst_stall2", 32'(s_stall_cnt), 32'd0);
        #3 arst_n = 1'b1;
        out_ready = 1'b1;
        #1 chk("arst_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("post_rst_valid", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Absolute time bound so the bench always ends on its own.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
